// File: rtl/uart_cmd_arb.sv
// uart_cmd_arb: round-robin arbiter sharing one UART command port between two requesters
module uart_cmd_arb #(
  parameter int CMD_WIDTH = 16,
  parameter int READ_WIDTH = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_vld,
  input  logic                  req1_vld,
  input  logic [CMD_WIDTH-1:0]  req0_cmd,
  input  logic [CMD_WIDTH-1:0]  req1_cmd,
  output logic                  req0_rdy,
  output logic                  req1_rdy,
  output logic                  req0_done,
  output logic                  req1_done,
  output logic                  req0_err,
  output logic                  req1_err,
  output logic [READ_WIDTH-1:0] rdata,
  output logic [CMD_WIDTH-1:0]  uart_cmd,
  output logic                  uart_cmd_vld,
  input  logic                  uart_cmd_rdy,
  input  logic                  uart_read_rdy,
  input  logic [READ_WIDTH-1:0] uart_read_data,
  output logic                  busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT_DONE = 2'd2, RESP = 2'd3;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic id, last_grant, seen_busy, gnt, accept, is_wr, comp, tmo;
  assign gnt = (req0_vld && req1_vld) ? ~last_grant : req1_vld;
  assign accept = !rst && state == IDLE && (req0_vld || req1_vld);
  assign req0_rdy = accept && !gnt;
  assign req1_rdy = accept && gnt;
  assign is_wr = uart_cmd[CMD_WIDTH-1];
  // a write is only complete once the UART has been seen busy after the transfer
  assign comp = state == WAIT_DONE && (is_wr ? seen_busy && uart_cmd_rdy : uart_read_rdy);
  assign tmo = state == WAIT_DONE && cnt == CW'(TIMEOUT - 1);
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      uart_cmd <= '0;
      uart_cmd_vld <= 1'b0;
      rdata <= '0;
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      req0_err <= 1'b0;
      req1_err <= 1'b0;
      seen_busy <= 1'b0;
      cnt <= '0;
      id <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      req0_err <= 1'b0;
      req1_err <= 1'b0;
      if (accept) begin
        uart_cmd <= gnt ? req1_cmd : req0_cmd;
        uart_cmd_vld <= 1'b1;
        id <= gnt;
        last_grant <= gnt;
        state <= ISSUE;
      end else if (state == ISSUE && uart_cmd_rdy) begin
        uart_cmd_vld <= 1'b0;
        cnt <= '0;
        seen_busy <= 1'b0;
        state <= WAIT_DONE;
      end else if (comp || tmo) begin
        req0_done <= !id;
        req1_done <= id;
        req0_err <= !comp && !id;
        req1_err <= !comp && id;
        if (!is_wr) rdata <= comp ? uart_read_data : '0;
        state <= RESP;
      end else if (state == WAIT_DONE) begin
        if (!uart_cmd_rdy) seen_busy <= 1'b1;
        cnt <= (&cnt) ? cnt : cnt + CW'(1);
      end else if (state == RESP) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_arb.sv
// tb_uart_cmd_arb: scenario tasks with a completion scoreboard for uart_cmd_arb
module tb_uart_cmd_arb;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_vld = 1'b0, req1_vld = 1'b0;
  logic [15:0] req0_cmd = '0, req1_cmd = '0;
  logic req0_rdy, req1_rdy, req0_done, req1_done, req0_err, req1_err;
  logic [7:0] rdata;
  logic [15:0] uart_cmd;
  logic uart_cmd_vld, busy;
  logic uart_cmd_rdy = 1'b1, uart_read_rdy = 1'b0;
  logic [7:0] uart_read_data = '0;
  typedef struct packed {logic id; logic err; logic rd_chk; logic [7:0] rd;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0, xfers = 0, dones = 0, x0, d0, seen;
  logic m_last;
  uart_cmd_arb #(.CMD_WIDTH(16), .READ_WIDTH(8), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .req0_vld(req0_vld), .req1_vld(req1_vld),
    .req0_cmd(req0_cmd), .req1_cmd(req1_cmd),
    .req0_rdy(req0_rdy), .req1_rdy(req1_rdy),
    .req0_done(req0_done), .req1_done(req1_done),
    .req0_err(req0_err), .req1_err(req1_err),
    .rdata(rdata), .uart_cmd(uart_cmd), .uart_cmd_vld(uart_cmd_vld),
    .uart_cmd_rdy(uart_cmd_rdy), .uart_read_rdy(uart_read_rdy),
    .uart_read_data(uart_read_data), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (!rst && uart_cmd_vld && uart_cmd_rdy) xfers++;
    if (req0_done || req1_done) dones++;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    req0_vld = 1'b1;
    step();
    @(negedge clk);
    n_cmp++; if (req0_rdy !== 1'b0) begin n_bad++; $display("FAIL rst_rdy: got %b want 0", req0_rdy); end
    n_cmp++;
    if ({busy, uart_cmd_vld, uart_cmd, rdata, req0_done, req1_done, req0_err, req1_err} !== '0) begin
      n_bad++; $display("FAIL rst_state: busy=%b vld=%b cmd=%h rdata=%h want all 0", busy, uart_cmd_vld, uart_cmd, rdata);
    end
    req0_vld = 1'b0;
    step();
    rst = 1'b0;
    m_last = 1'b1;
    step();
  endtask
  task automatic test_write();
    req0_vld = 1'b1; req0_cmd = 16'h8A55; req1_vld = 1'b0;
    @(negedge clk);
    n_cmp++; if ({req1_rdy, req0_rdy} !== 2'b01) begin n_bad++; $display("FAIL wr_grant: got %b want 01", {req1_rdy, req0_rdy}); end
    m_last = 1'b0;
    sb.push_back('{id: 1'b0, err: 1'b0, rd_chk: 1'b0, rd: 8'h00});
    x0 = xfers;
    step();
    req0_vld = 1'b0;
    @(negedge clk);
    n_cmp++; if (uart_cmd_vld !== 1'b1 || uart_cmd !== 16'h8A55) begin n_bad++; $display("FAIL wr_issue: got vld=%b cmd=%h want 1/8a55", uart_cmd_vld, uart_cmd); end
    step();
    uart_cmd_rdy = 1'b0;
    repeat (20) step();
    uart_cmd_rdy = 1'b1;
    @(negedge clk);
    n_cmp++; if (req0_done !== 1'b0) begin n_bad++; $display("FAIL wr_early: got done=%b want 0", req0_done); end
    step();
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++; if ({req1_done, req0_done} !== (e.id ? 2'b10 : 2'b01) || {req1_err, req0_err} !== {e.id & e.err, !e.id & e.err}) begin
      n_bad++; $display("FAIL wr_done: got done=%b err=%b want id=%b err=%b", {req1_done, req0_done}, {req1_err, req0_err}, e.id, e.err);
    end
    step();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || xfers - x0 !== 1) begin n_bad++; $display("FAIL wr_end: got busy=%b xfers=%0d want 0/1", busy, xfers - x0); end
  endtask
  task automatic test_read();
    step();
    req1_vld = 1'b1; req1_cmd = 16'h0123;
    @(negedge clk);
    n_cmp++; if ({req1_rdy, req0_rdy} !== 2'b10) begin n_bad++; $display("FAIL rd_grant: got %b want 10", {req1_rdy, req0_rdy}); end
    m_last = 1'b1;
    sb.push_back('{id: 1'b1, err: 1'b0, rd_chk: 1'b1, rd: 8'hC3});
    step();
    req1_vld = 1'b0;
    @(negedge clk);
    n_cmp++; if (uart_cmd_vld !== 1'b1 || uart_cmd !== 16'h0123) begin n_bad++; $display("FAIL rd_issue: got vld=%b cmd=%h want 1/0123", uart_cmd_vld, uart_cmd); end
    repeat (3) step();
    uart_read_rdy = 1'b1; uart_read_data = 8'hC3;
    @(negedge clk);
    n_cmp++; if (req1_done !== 1'b0) begin n_bad++; $display("FAIL rd_early: got done=%b want 0", req1_done); end
    step();
    uart_read_rdy = 1'b0; uart_read_data = 8'h5A;
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++; if ({req1_done, req0_done} !== (e.id ? 2'b10 : 2'b01) || (req0_err | req1_err) !== e.err || rdata !== e.rd) begin
      n_bad++; $display("FAIL rd_done: got done=%b err=%b rdata=%h want id=%b err=%b rdata=%h", {req1_done, req0_done}, {req1_err, req0_err}, rdata, e.id, e.err, e.rd);
    end
    step();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || rdata !== 8'hC3) begin n_bad++; $display("FAIL rd_idle: got busy=%b rdata=%h want 0/c3", busy, rdata); end
  endtask
  task automatic test_tie();
    test_reset();
    req0_vld = 1'b1; req1_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic g;
      req0_cmd = 16'h0100 + 16'(i); req1_cmd = 16'h0200 + 16'(i);
      g = ~m_last;
      @(negedge clk);
      n_cmp++; if ({req1_rdy, req0_rdy} !== (g ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL tie_grant%0d: got %b want %b", i, {req1_rdy, req0_rdy}, g ? 2'b10 : 2'b01); end
      m_last = g;
      sb.push_back('{id: g, err: 1'b0, rd_chk: 1'b1, rd: 8'h10 + 8'(i)});
      step();
      step();
      uart_read_rdy = 1'b1; uart_read_data = 8'h10 + 8'(i);
      step();
      uart_read_rdy = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++; if ({req1_done, req0_done} !== (e.id ? 2'b10 : 2'b01) || rdata !== e.rd) begin
        n_bad++; $display("FAIL tie_done%0d: got done=%b rdata=%h want id=%b rdata=%h", i, {req1_done, req0_done}, rdata, e.id, e.rd);
      end
      step();
    end
    req0_vld = 1'b0; req1_vld = 1'b0;
  endtask
  task automatic test_timeout();
    req1_vld = 1'b1; req1_cmd = 16'h0055;
    @(negedge clk);
    n_cmp++; if (req1_rdy !== 1'b1) begin n_bad++; $display("FAIL to_grant: got %b want 1", req1_rdy); end
    m_last = 1'b1;
    sb.push_back('{id: 1'b1, err: 1'b1, rd_chk: 1'b1, rd: 8'h00});
    step();
    req1_vld = 1'b0;
    step();
    seen = 0;
    repeat (64) begin
      @(negedge clk);
      if (req0_done || req1_done) seen++;
      step();
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL to_early: got %0d done pulses want 0", seen); end
    uart_read_rdy = 1'b1; uart_read_data = 8'hFF;
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++; if ({req1_done, req0_done} !== (e.id ? 2'b10 : 2'b01) || {req1_err, req0_err} !== {e.id & e.err, !e.id & e.err} || rdata !== e.rd) begin
      n_bad++; $display("FAIL to_done: got done=%b err=%b rdata=%h want id=%b err=%b rdata=%h", {req1_done, req0_done}, {req1_err, req0_err}, rdata, e.id, e.err, e.rd);
    end
    step();
    uart_read_rdy = 1'b0;
    @(negedge clk);
    n_cmp++; if (rdata !== 8'h00 || busy !== 1'b0 || (req0_done | req1_done) !== 1'b0) begin
      n_bad++; $display("FAIL to_stray: got rdata=%h busy=%b done=%b want 00/0/0", rdata, busy, req0_done | req1_done);
    end
    step();
  endtask
  task automatic test_backpressure();
    uart_cmd_rdy = 1'b0;
    req0_vld = 1'b1; req0_cmd = 16'h0042;
    @(negedge clk);
    n_cmp++; if (req0_rdy !== 1'b1) begin n_bad++; $display("FAIL bp_grant: got %b want 1", req0_rdy); end
    m_last = 1'b0;
    sb.push_back('{id: 1'b0, err: 1'b0, rd_chk: 1'b1, rd: 8'h77});
    x0 = xfers;
    step();
    req0_vld = 1'b0; req0_cmd = 16'hFFFF;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (uart_cmd_vld === 1'b1 && uart_cmd === 16'h0042) seen++;
      step();
    end
    n_cmp++; if (seen !== 5) begin n_bad++; $display("FAIL bp_stable: got %0d stable cycles want 5", seen); end
    uart_cmd_rdy = 1'b1;
    step();
    @(negedge clk);
    n_cmp++; if (uart_cmd_vld !== 1'b0) begin n_bad++; $display("FAIL bp_drop: got vld=%b want 0", uart_cmd_vld); end
    uart_read_rdy = 1'b1; uart_read_data = 8'h77;
    step();
    uart_read_rdy = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++; if ({req1_done, req0_done} !== (e.id ? 2'b10 : 2'b01) || rdata !== e.rd || xfers - x0 !== 1) begin
      n_bad++; $display("FAIL bp_done: got done=%b rdata=%h xfers=%0d want id=%b rdata=%h xfers=1", {req1_done, req0_done}, rdata, xfers - x0, e.id, e.rd);
    end
    step();
  endtask
  task automatic test_reset_mid();
    req0_vld = 1'b1; req0_cmd = 16'h8001;
    step();
    req0_vld = 1'b0;
    step();
    uart_cmd_rdy = 1'b0;
    repeat (3) step();
    d0 = dones;
    rst = 1'b1; req0_vld = 1'b1; req1_vld = 1'b1;
    @(negedge clk);
    n_cmp++; if ({req1_rdy, req0_rdy} !== 2'b00) begin n_bad++; $display("FAIL rm_rdy: got %b want 00", {req1_rdy, req0_rdy}); end
    step();
    rst = 1'b0; uart_cmd_rdy = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, uart_cmd_vld, uart_cmd, rdata, req0_done, req1_done, req0_err, req1_err} !== '0) begin
      n_bad++; $display("FAIL rm_state: busy=%b vld=%b cmd=%h rdata=%h done=%b want all 0", busy, uart_cmd_vld, uart_cmd, rdata, {req1_done, req0_done});
    end
    n_cmp++; if ({req1_rdy, req0_rdy} !== 2'b01) begin n_bad++; $display("FAIL rm_tie: got %b want 01", {req1_rdy, req0_rdy}); end
    step();
    req0_vld = 1'b0; req1_vld = 1'b0;
    repeat (3) step();
    n_cmp++; if (dones !== d0) begin n_bad++; $display("FAIL rm_nodone: got %0d done pulses want 0", dones - d0); end
  endtask
  initial begin
    test_reset();
    test_write();
    test_read();
    test_tie();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL sb_empty: got %0d pending want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
